// File: rtl/ef_pwm32_deadtime_if.sv
// Control and PWM signal bundle between the ef_pwm32 generator/bus wrapper
// and the dead-time/fault stage.
interface ef_pwm32_deadtime_if #(
  parameter int unsigned DW = 8
);
  logic          en;
  logic          mode;
  logic [DW-1:0] dt_rise;
  logic [DW-1:0] dt_fall;
  logic          pwmA;
  logic          pwmB;
  logic          trip;
  logic          trip_clr;
  logic          pwmA_o;
  logic          pwmB_o;
  logic          tripped;

  modport master (
    output en, mode, dt_rise, dt_fall, pwmA, pwmB, trip, trip_clr,
    input  pwmA_o, pwmB_o, tripped
  );

  modport slave (
    input  en, mode, dt_rise, dt_fall, pwmA, pwmB, trip, trip_clr,
    output pwmA_o, pwmB_o, tripped
  );
endinterface

// File: rtl/ef_pwm32_deadtime.sv
// Dead-time insertion and latched fault trip for a PWM pair: rising edges are
// delayed per channel, falling edges pass through on the next clock.
module ef_pwm32_deadtime #(
  parameter int unsigned DW = 8
) (
  input  logic                clk,
  input  logic                rst,
  ef_pwm32_deadtime_if.slave  bus
);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    DELAY = 2'd1,
    ON    = 2'd2
  } ch_state_e;

  typedef struct packed {
    ch_state_e     st;
    logic [DW-1:0] cnt;
  } ch_t;

  ch_t           cha_q, cha_d;
  ch_t           chb_q, chb_d;
  logic          tripped_q, tripped_d;
  logic          mode_q;
  logic          kill;
  logic          src_b;
  logic [DW-1:0] dly_b;

  // The delay is captured into cnt on entry to DELAY, so later dt_* writes
  // only affect the next qualification.
  function automatic ch_t ch_next(input ch_t cur, input logic s,
                                  input logic [DW-1:0] d, input logic k);
    ch_t n;
    n.st  = cur.st;
    n.cnt = '0;
    if (k) begin
      n.st = OFF;
    end else begin
      case (cur.st)
        OFF: begin
          if (s) begin
            if (d == '0) begin
              n.st = ON;
            end else begin
              n.st  = DELAY;
              n.cnt = d - DW'(1);
            end
          end
        end
        DELAY: begin
          if (!s) begin
            n.st = OFF;
          end else if (cur.cnt == '0) begin
            n.st = ON;
          end else begin
            n.cnt = cur.cnt - DW'(1);
          end
        end
        ON: begin
          if (!s) n.st = OFF;
        end
        default: n.st = OFF;
      endcase
    end
    return n;
  endfunction

  always_comb begin
    src_b = bus.mode ? ~bus.pwmA : bus.pwmB;
    dly_b = bus.mode ? bus.dt_fall : bus.dt_rise;

    tripped_d = tripped_q;
    if (bus.trip) begin
      tripped_d = 1'b1;
    end else if (bus.trip_clr) begin
      tripped_d = 1'b0;
    end

    // A mode change is detected against the registered mode, so both
    // channels drop on the edge after the change and re-qualify afterwards.
    kill = ~bus.en | bus.trip | tripped_q | (bus.mode != mode_q);

    cha_d = ch_next(cha_q, bus.pwmA, bus.dt_rise, kill);
    chb_d = ch_next(chb_q, src_b, dly_b, kill);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cha_q     <= '0;
      chb_q     <= '0;
      tripped_q <= 1'b0;
      mode_q    <= bus.mode;
    end else begin
      cha_q     <= cha_d;
      chb_q     <= chb_d;
      tripped_q <= tripped_d;
      mode_q    <= bus.mode;
    end
  end

  assign bus.pwmA_o  = (cha_q.st == ON);
  assign bus.pwmB_o  = (chb_q.st == ON);
  assign bus.tripped = tripped_q;

endmodule

// File: tb/tb_ef_pwm32_deadtime.sv
// Directed bench for ef_pwm32_deadtime: a per-cycle vector table plus
// hand-written multi-cycle sequences with hand-computed expectations.
module tb_ef_pwm32_deadtime;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;

  ef_pwm32_deadtime_if #(.DW(8)) bus ();

  ef_pwm32_deadtime #(.DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       mode;
    logic [7:0] dr;
    logic [7:0] df;
    logic       a;
    logic       b;
    logic       trip;
    logic       clr;
    logic       ea;
    logic       eb;
    logic       et;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic en, input logic mode, input logic [7:0] dr,
                     input logic [7:0] df, input logic a, input logic b,
                     input logic trip, input logic clr, input logic ea,
                     input logic eb, input logic et);
    vec_t v;
    v.en = en; v.mode = mode; v.dr = dr; v.df = df; v.a = a; v.b = b;
    v.trip = trip; v.clr = clr; v.ea = ea; v.eb = eb; v.et = et;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0b expected %0b", nm, act, exp);
  endtask

  task automatic chk3(input string nm, input logic ea, input logic eb, input logic et);
    chk({nm, ".A"}, bus.pwmA_o, ea);
    chk({nm, ".B"}, bus.pwmB_o, eb);
    chk({nm, ".T"}, bus.tripped, et);
  endtask

  initial begin
    int ovl;
    logic ea, eb;

    bus.en = 1'b1; bus.mode = 1'b0; bus.dt_rise = 8'd0; bus.dt_fall = 8'd0;
    bus.pwmA = 1'b1; bus.pwmB = 1'b1; bus.trip = 1'b0; bus.trip_clr = 1'b0;
    rst = 1'b1;
    step(); step();
    chk3("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    bus.pwmA = 1'b0; bus.pwmB = 1'b0;

    // en mode dr df a b trip clr | A B T
    // 4-cycle pulse swallowed at D=4, 5-cycle pulse gives one cycle
    add(1,0,4,0, 0,0,0,0, 0,0,0);
    repeat (4) add(1,0,4,0, 1,0,0,0, 0,0,0);
    repeat (2) add(1,0,4,0, 0,0,0,0, 0,0,0);
    repeat (4) add(1,0,4,0, 1,0,0,0, 0,0,0);
    add(1,0,4,0, 1,0,0,0, 1,0,0);
    repeat (2) add(1,0,4,0, 0,0,0,0, 0,0,0);
    // D=0: one register stage on both channels
    add(1,0,0,0, 1,0,0,0, 1,0,0);
    add(1,0,0,0, 0,1,0,0, 0,1,0);
    add(1,0,0,0, 1,1,0,0, 1,1,0);
    add(1,0,0,0, 1,1,0,0, 1,1,0);
    add(1,0,0,0, 0,0,0,0, 0,0,0);
    // enable gating, full delay after en rises
    repeat (2) add(0,0,2,0, 1,0,0,0, 0,0,0);
    repeat (2) add(1,0,2,0, 1,0,0,0, 0,0,0);
    add(1,0,2,0, 1,0,0,0, 1,0,0);
    // trip mid-ON, trip wins over clear, clear, full delay again
    add(1,0,2,0, 1,0,1,0, 0,0,1);
    add(1,0,2,0, 1,0,1,1, 0,0,1);
    add(1,0,2,0, 1,0,0,0, 0,0,1);
    add(1,0,2,0, 1,0,0,1, 0,0,0);
    repeat (2) add(1,0,2,0, 1,0,0,0, 0,0,0);
    add(1,0,2,0, 1,0,0,0, 1,0,0);
    // latch works with en=0
    add(0,0,2,0, 0,0,1,0, 0,0,1);
    add(0,0,2,0, 0,0,0,1, 0,0,0);
    add(0,0,2,0, 0,0,0,0, 0,0,0);

    foreach (tbl[i]) begin
      bus.en = tbl[i].en; bus.mode = tbl[i].mode;
      bus.dt_rise = tbl[i].dr; bus.dt_fall = tbl[i].df;
      bus.pwmA = tbl[i].a; bus.pwmB = tbl[i].b;
      bus.trip = tbl[i].trip; bus.trip_clr = tbl[i].clr;
      step();
      chk3($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].et);
    end

    // dt_rise 5->1 during DELAY
    bus.en = 1'b1; bus.dt_rise = 8'd5; bus.pwmA = 1'b0;
    step();
    bus.pwmA = 1'b1;
    step(); chk("dtchg.k0", bus.pwmA_o, 1'b0);
    bus.dt_rise = 8'd1;
    for (int i = 1; i < 5; i++) begin
      step(); chk($sformatf("dtchg.k%0d", i), bus.pwmA_o, 1'b0);
    end
    step(); chk("dtchg.k5", bus.pwmA_o, 1'b1);
    bus.pwmA = 1'b0;
    step(); chk("dtchg.fall", bus.pwmA_o, 1'b0);
    bus.pwmA = 1'b1;
    step(); chk("dtchg.n0", bus.pwmA_o, 1'b0);
    step(); chk("dtchg.n1", bus.pwmA_o, 1'b1);

    // mode toggle while both outputs high
    bus.dt_rise = 8'd1; bus.dt_fall = 8'd1; bus.pwmA = 1'b0; bus.pwmB = 1'b0;
    step();
    bus.pwmA = 1'b1; bus.pwmB = 1'b1;
    step(); chk3("mtog.q0", 1'b0, 1'b0, 1'b0);
    step(); chk3("mtog.on", 1'b1, 1'b1, 1'b0);
    bus.mode = 1'b1;
    step(); chk3("mtog.kill", 1'b0, 1'b0, 1'b0);
    step(); chk3("mtog.dly", 1'b0, 1'b0, 1'b0);
    step(); chk3("mtog.A", 1'b1, 1'b0, 1'b0);
    bus.pwmA = 1'b0;
    step(); chk3("mtog.gap", 1'b0, 1'b0, 1'b0);
    step(); chk3("mtog.B", 1'b0, 1'b1, 1'b0);

    // maximum delay 255
    bus.mode = 1'b0; bus.dt_rise = 8'd255; bus.pwmA = 1'b0; bus.pwmB = 1'b0;
    step(); step();
    bus.pwmA = 1'b1;
    repeat (255) step();
    chk("dmax.low", bus.pwmA_o, 1'b0);
    step(); chk("dmax.high", bus.pwmA_o, 1'b1);

    // reset mid-DELAY and mid-ON, reset clears tripped
    bus.dt_rise = 8'd5; bus.pwmA = 1'b0;
    step();
    bus.pwmA = 1'b1;
    step(); step();
    rst = 1'b1;
    step(); chk3("rst.dly", 1'b0, 1'b0, 1'b0);
    rst = 1'b0; bus.dt_rise = 8'd0;
    step(); chk("rst.on", bus.pwmA_o, 1'b1);
    rst = 1'b1;
    step(); chk("rst.onclr", bus.pwmA_o, 1'b0);
    rst = 1'b0; bus.trip = 1'b1;
    step(); chk("rst.trip", bus.tripped, 1'b1);
    bus.trip = 1'b0; rst = 1'b1;
    step(); chk("rst.tclr", bus.tripped, 1'b0);

    // complementary mode, dt_rise=3 dt_fall=2, 20 hi / 20 lo
    bus.mode = 1'b1; bus.dt_rise = 8'd3; bus.dt_fall = 8'd2; bus.pwmA = 1'b0;
    step();
    rst = 1'b0;
    repeat (5) step();
    chk3("comp.idle", 1'b0, 1'b1, 1'b0);
    ovl = 0;
    for (int c = 0; c < 80; c++) begin
      bus.pwmA = ((c % 40) < 20);
      step();
      ea = ((c % 40) >= 3) && ((c % 40) < 20);
      eb = ((c % 40) >= 22);
      chk($sformatf("comp.A%0d", c), bus.pwmA_o, ea);
      chk($sformatf("comp.B%0d", c), bus.pwmB_o, eb);
      if (bus.pwmA_o && bus.pwmB_o) ovl++;
    end
    chk("comp.overlap", (ovl != 0), 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
